serial_addsub: RTL



---
 rtl/serial_addsub.sv | 110 +++++++++++
 1 files changed

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial full adder / full subtractor with a start/done
// handshake. Operands are captured on an accepted start, then one bit is
// resolved per clock, LSB first, through a single full-add/full-subtract
// cell and a carry/borrow register.
module serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic           sh_op;
  logic           carry;
  logic [CW-1:0]  cnt;

  logic             x;
  logic             y;
  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH-1:0] result_next;

  // Single full-add / full-subtract cell on the current LSBs of the operands.
  always_comb begin
    x           = sh_a[0];
    y           = sh_b[0];
    sum_bit     = x ^ y ^ carry;
    if (sh_op) begin
      carry_next = (~x & y) | (~(x ^ y) & carry);
    end else begin
      carry_next = (x & y) | (x & carry) | (y & carry);
    end
    // Shift right and insert the new bit at the MSB; written as a shift plus
    // bit insert so that WIDTH=1 needs no empty slice.
    result_next            = result >> 1;
    result_next[WIDTH-1]   = sum_bit;
  end

  // Control FSM, operand shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sh_a   <= '0;
      sh_b   <= '0;
      sh_op  <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            sh_op <= op;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sh_a   <= sh_a >> 1;
          sh_b   <= sh_b >> 1;
          carry  <= carry_next;
          result <= result_next;
          cout   <= carry_next;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
